// File: rtl/alu_share_ctrl.sv
`default_nettype none
// alu_share_ctrl: one shared W-bit ALU, round-robin arbitrated between two valid/ready
// requesters; result and flags are registered and held until the owner accepts them.
module alu_share_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_opc0,
  input  logic [2:0]       req_opc1,
  input  logic [W-1:0]     req_ina0,
  input  logic [W-1:0]     req_ina1,
  input  logic [W-1:0]     req_inb0,
  input  logic [W-1:0]     req_inb1,
  input  logic             req_inc0,
  input  logic             req_inc1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [W-1:0]     rsp_w,
  output logic             rsp_zer,
  output logic             rsp_neg,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam logic [W-1:0]     ONE     = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [2:0]        opc_q;
  logic [W-1:0]      ina_q;
  logic [W-1:0]      inb_q;
  logic              inc_q;
  logic              any_valid;
  logic              sel;
  logic [W-1:0]      alu_w;
  logic signed [W-1:0] b_asr;

  // On a tie the port that did not win last time is chosen.
  assign any_valid = |req_valid;
  assign sel       = (&req_valid) ? ~last_grant : req_valid[1];
  assign req_ready = (state == S_IDLE && any_valid) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != S_IDLE);

  // Kept as a separate signed signal so the shift stays arithmetic.
  assign b_asr = $signed(inb_q) >>> 1;

  always_comb begin
    alu_w = '0;
    case (opc_q)
      3'b000:  alu_w = ~ina_q + ONE;
      3'b001:  alu_w = ina_q + ONE;
      3'b010:  alu_w = ina_q + inb_q + {{(W-1){1'b0}}, inc_q};
      3'b011:  alu_w = ina_q + b_asr;
      3'b100:  alu_w = ina_q & inb_q;
      3'b101:  alu_w = ina_q | inb_q;
      3'b110:  alu_w = {ina_q[W/2-1:0], inb_q[W/2-1:0]};
      default: alu_w = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      opc_q      <= '0;
      ina_q      <= '0;
      inb_q      <= '0;
      inc_q      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_w      <= '0;
      rsp_zer    <= 1'b0;
      rsp_neg    <= 1'b0;
      done_cnt0  <= '0;
      done_cnt1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant      <= sel;
            last_grant <= sel;
            opc_q      <= sel ? req_opc1 : req_opc0;
            ina_q      <= sel ? req_ina1 : req_ina0;
            inb_q      <= sel ? req_inb1 : req_inb0;
            inc_q      <= sel ? req_inc1 : req_inc0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_w     <= alu_w;
          rsp_zer   <= (alu_w == '0);
          rsp_neg   <= alu_w[W-1];
          rsp_valid <= grant ? 2'b10 : 2'b01;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[grant]) begin
            rsp_valid <= 2'b00;
            if (grant) done_cnt1 <= done_cnt1 + CNT_ONE;
            else       done_cnt0 <= done_cnt0 + CNT_ONE;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// tb_alu_share_ctrl: directed table, multi-cycle corner sequences and randomized
// traffic checked against an arithmetic reference model of the shared ALU.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  opc_d [2];
  logic [15:0] a_d [2];
  logic [15:0] b_d [2];
  logic        c_d [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_w;
  logic        rsp_zer;
  logic        rsp_neg;
  logic        busy;
  logic [7:0]  done_cnt0;
  logic [7:0]  done_cnt1;

  int          total;
  int          bad;
  int          cyc;
  logic [7:0]  exp_cnt [2];
  logic        last_m;

  alu_share_ctrl #(.W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opc0(opc_d[0]), .req_opc1(opc_d[1]),
    .req_ina0(a_d[0]), .req_ina1(a_d[1]),
    .req_inb0(b_d[0]), .req_inb1(b_d[1]),
    .req_inc0(c_d[0]), .req_inc1(c_d[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_w(rsp_w), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg),
    .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          p;
    logic [2:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    int          hold;
    logic [15:0] w;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    int ai, bi, bs, r;
    ai = a; bi = b; r = 0;
    case (op)
      3'd0: r = 65536 - ai;
      3'd1: r = ai + 1;
      3'd2: r = ai + bi + (c ? 1 : 0);
      3'd3: begin
        bs = (bi >= 32768) ? bi - 65536 : bi;
        r  = ai + (bs - ((bs % 2 != 0) ? 1 : 0)) / 2;  // floor(bs/2)
      end
      3'd4: r = ai & bi;
      3'd5: r = ai | bi;
      3'd6: r = (ai % 256) * 256 + (bi % 256);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic [2:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
    opc_d[p] = opc; a_d[p] = a; b_d[p] = b; c_d[p] = c;
    req_valid[p] = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("reset", {rsp_valid, req_ready, busy, rsp_zer, rsp_neg, rsp_w, done_cnt0, done_cnt1}, 48'd0);
    rst_n = 1'b1;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0; last_m = 1'b1;
  endtask

  // Called at a negedge with the request(s) already presented; serves port p.
  task automatic serve(input int p, input int hold, input logic [15:0] ew,
                       input bit pulse, input string nm);
    int k;
    logic [1:0] bm;
    bm = (p == 1) ? 2'b10 : 2'b01;
    k = 0;
    #1;
    while (req_ready == 2'b00 && k < 8) begin @(negedge clk); #1; k++; end
    chk({nm, " grant"}, req_ready, bm);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    opc_d[p] = 3'($urandom); a_d[p] = 16'($urandom); b_d[p] = 16'($urandom); c_d[p] = 1'($urandom);
    last_m = (p == 1);
    @(negedge clk);
    chk({nm, " exec"}, {rsp_valid, req_ready, busy}, 5'b00001);
    if (pulse) req_valid[1-p] = 1'b1;
    @(negedge clk);
    chk({nm, " rsp"}, {rsp_valid, rsp_w, rsp_zer, rsp_neg}, {bm, ew, ew == 16'd0, ew[15]});
    if (pulse) req_valid[1-p] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      rsp_ready[1-p] = ~rsp_ready[1-p];
      @(negedge clk);
      chk({nm, " hold"}, {rsp_valid, rsp_w, rsp_zer, rsp_neg, busy}, {bm, ew, ew == 16'd0, ew[15], 1'b1});
    end
    rsp_ready[1-p] = 1'b0;
    rsp_ready[p]   = 1'b1;
    @(posedge clk); #1;
    rsp_ready[p] = 1'b0;
    exp_cnt[p] = exp_cnt[p] + 8'd1;
    chk({nm, " done"}, {rsp_valid, busy, rsp_w, done_cnt0, done_cnt1},
        {2'b00, 1'b0, ew, exp_cnt[0], exp_cnt[1]});
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, prev;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    for (int q = 0; q < 2; q++) begin opc_d[q] = 3'd0; a_d[q] = 16'd0; b_d[q] = 16'd0; c_d[q] = 1'b0; end

    tbl[0]  = '{0, 3'b010, 16'h7FFF, 16'h0001, 1'b1, 3, 16'h8001};
    tbl[1]  = '{1, 3'b011, 16'h0010, 16'h8000, 1'b0, 0, 16'hC010};
    tbl[2]  = '{1, 3'b100, 16'h0F0F, 16'hF0F0, 1'b0, 1, 16'h0000};
    tbl[3]  = '{0, 3'b111, 16'h1234, 16'h5678, 1'b1, 0, 16'h0000};
    tbl[4]  = '{0, 3'b000, 16'h0001, 16'h0000, 1'b0, 0, 16'hFFFF};
    tbl[5]  = '{1, 3'b110, 16'h12AB, 16'h34CD, 1'b0, 2, 16'hABCD};
    tbl[6]  = '{0, 3'b001, 16'hFFFF, 16'h0000, 1'b0, 0, 16'h0000};
    tbl[7]  = '{1, 3'b101, 16'h00F0, 16'h0F00, 1'b0, 0, 16'h0FF0};
    tbl[8]  = '{0, 3'b011, 16'h0001, 16'h0003, 1'b0, 0, 16'h0002};
    tbl[9]  = '{1, 3'b010, 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000};
    tbl[10] = '{0, 3'b011, 16'h0000, 16'hFFFF, 1'b0, 1, 16'hFFFF};

    reset_dut();
    for (int i = 0; i < 11; i++) begin
      set_req(tbl[i].p, tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].c);
      serve(tbl[i].p, tbl[i].hold, tbl[i].w, 1'b0, $sformatf("vec%0d", i));
    end

    // Simultaneous requests: port 0 first after reset, then alternation.
    reset_dut();
    set_req(0, 3'b000, 16'h0001, 16'h0000, 1'b0);
    set_req(1, 3'b110, 16'h12AB, 16'h34CD, 1'b0);
    serve(0, 1, 16'hFFFF, 1'b0, "tie p0");
    serve(1, 0, 16'hABCD, 1'b0, "tie p1");
    set_req(0, 3'b001, 16'h0010, 16'h0000, 1'b0);
    set_req(1, 3'b101, 16'h8000, 16'h0001, 1'b0);
    serve(0, 2, 16'h0011, 1'b0, "alt p0");
    serve(1, 0, 16'h8001, 1'b0, "alt p1");

    // Port 0 request pulsed only while busy is never granted.
    set_req(1, 3'b100, 16'hFFFF, 16'h00FF, 1'b0);
    serve(1, 1, 16'h00FF, 1'b1, "pulse");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pulse idle", {busy, rsp_valid, req_ready}, 5'd0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      int w;
      logic [15:0] e;
      m = 2'($urandom_range(1, 3));
      for (int q = 0; q < 2; q++)
        if (m[q]) set_req(q, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      while (m != 2'b00) begin
        w = (m == 2'b11) ? (last_m ? 0 : 1) : (m[1] ? 1 : 0);
        e = alu_ref(opc_d[w], a_d[w], b_d[w], c_d[w]);
        serve(w, $urandom_range(0, 2), e, 1'b0, $sformatf("rand%0d", n));
        m[w] = 1'b0;
      end
    end

    // Reset while a response is pending abandons it.
    set_req(1, 3'b101, 16'h00F0, 16'h0F00, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("midrst rsp", {rsp_valid, rsp_w}, {2'b10, 16'h0FF0});
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst clr", {rsp_valid, busy, rsp_w, done_cnt0, done_cnt1}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0; last_m = 1'b1;
    set_req(0, 3'b010, 16'h0001, 16'h0002, 1'b1);
    serve(0, 0, 16'h0004, 1'b0, "postrst");

    // 256 back-to-back port 0 ops: 3-cycle interval and counter wrap.
    reset_dut();
    set_req(0, 3'b001, 16'h0001, 16'h0000, 1'b0);
    rsp_ready = 2'b01;
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      #1;
      while (!req_ready[0] && k < 8) begin @(negedge clk); #1; k++; end
      chk("wrap cnt", done_cnt0, i[7:0]);
      if (i > 0) chk("wrap gap", cyc - prev, 48'd3);
      prev = cyc;
      @(posedge clk); #1;
      if (i == 255) req_valid[0] = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("wrap end", {done_cnt0, done_cnt1, rsp_valid, busy}, 48'd0);
    rsp_ready = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one 16-bit combinational ALU (opcode set below) between two independent requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- A 3-state FSM arbitrates round-robin, latches operands, executes in one cycle, registers the result and flags, and holds the response until the requester accepts it.
- Also keeps a per-port completed-operation counter for status.

Parameters:
- W, 16, ALU data width (operand/result width; byte-merge op uses W/2 halves).
- CNT_W, 8, width of per-port completion counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  2  per-port request valid (bit i = port i).
- req_ready  output  2  per-port request accept.
- req_opc0 / req_opc1  input  3  opcode, port 0 / 1.
- req_ina0 / req_ina1  input  W  operand A.
- req_inb0 / req_inb1  input  W  operand B.
- req_inc0 / req_inc1  input  1  carry-in.
- rsp_valid  output  2  per-port response valid.
- rsp_ready  input  2  per-port response accept.
- rsp_w  output  W  registered result (shared; meaningful for the port whose rsp_valid is high).
- rsp_zer  output  1  result == 0.
- rsp_neg  output  1  result[W-1].
- busy  output  1  FSM not in IDLE.
- done_cnt0 / done_cnt1  output  CNT_W  completed responses per port, wrapping.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - rsp_valid=0, req_ready=0, rsp_w=0, rsp_zer=0, rsp_neg=0.
  - done_cnt0/1=0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset mid-operation abandons the op; no response is issued.
- ALU ops (mod 2^W):
  - 000: ~A+1.
  - 001: A+1.
  - 010: A+B+C.
  - 011: A + (B arithmetic-shift-right 1).
  - 100: A&B.
  - 101: A|B.
  - 110: {A[7:0],B[7:0]}.
  - 111: result 0.
  - zer = (w==0); neg = w[W-1].
- IDLE:
  - req_ready is combinational. Only one bit may be high, and only in IDLE.
  - Grant: if exactly one req_valid is set, grant it. If both are set, grant the port != last_grant.
  - Assert req_ready for the granted port. The handshake completes that cycle.
  - At the edge: latch opc/ina/inb/inc of the granted port, record grant, last_grant<=grant, go to EXEC.
- EXEC (1 cycle):
  - Compute the ALU on the latched operands.
  - Register into rsp_w/rsp_zer/rsp_neg. Go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[grant]=1; the other bit is 0.
  - Result/flags are held stable until accepted.
  - On rsp_ready[grant]=1: increment done_cnt[grant] (wraps 2^CNT_W-1 -> 0), rsp_valid<=0, go to IDLE.
  - rsp_ready of the non-granted port is ignored.
- Latency: request handshake at edge T → rsp_valid high from cycle T+2. Minimum issue interval is 3 cycles per operation (IDLE/EXEC/RESP with immediate rsp_ready).
- A requester deasserting req_valid before handshake is legal; no grant is made.
- Operand changes after the handshake do not affect the result.
- rsp_w/flags keep their last value after the response completes.
- busy = (state != IDLE).

Test Plan:
- Reset, then port0 opc=010, A=0x7FFF, B=0x0001, C=1 → req_ready=01 same cycle. 2 cycles later rsp_valid=01, rsp_w=0x8001, neg=1, zer=0. Hold rsp_ready=0 for 3 cycles → outputs stable. Then rsp_ready=01 → done_cnt0=1, back to IDLE.
- Both ports valid simultaneously after reset: port0 opc=000 A=0x0001; port1 opc=110 A=0x12AB B=0x34CD.
  - Port0 served first: w=0xFFFF, neg=1.
  - Port1 served next: w=0xABCD.
  - Third simultaneous request → port0 granted (alternation).
- Port1 opc=011, A=0x0010, B=0x8000 → w=0xC010. Port1 opc=100, A=0x0F0F, B=0xF0F0 → w=0x0000, zer=1. Port0 opc=111 → w=0, zer=1, neg=0.
- Mid-RESP reset: issue op, assert rst_n=0 while rsp_valid=1 → next cycle rsp_valid=0, busy=0, counters=0, rsp_w=0. The next request is served normally.
- Counter wrap: 256 consecutive port0 ops with rsp_ready tied high → done_cnt0 returns to 0, done_cnt1 stays 0. Issue interval is exactly 3 cycles.
- Port0 req_valid pulsed while busy, then dropped before IDLE → never granted, no response. Port1 rsp_ready toggling during a port0 response has no effect.
